// File: rtl/ram32x8_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram32x8_fifo_ctrl
// Brief    : Runs a 32x8 level-sensitive LUT-RAM as a 32-entry byte FIFO with
//            a registered, address/data-framed write-enable pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ram32x8_fifo_ctrl #(
    parameter bit RD_PRIORITY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    input  logic       rd_req,
    output logic       rd_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       full,
    output logic       empty,
    output logic [5:0] count,
    output logic       ram_we,
    output logic [7:0] ram_d,
    output logic [4:0] ram_a,
    input  logic [7:0] ram_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_SETUP  = 3'd1,
        S_W_PULSE  = 3'd2,
        S_W_HOLD   = 3'd3,
        S_R_ADDR   = 3'd4,
        S_R_SAMPLE = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_wptr;
    logic [4:0] r_rptr;
    logic [5:0] r_count;
    logic       r_ram_we;
    logic [7:0] r_ram_d;
    logic [4:0] r_ram_a;
    logic [7:0] r_rd_data;
    logic       r_rd_valid;

    logic w_idle;
    logic w_full;
    logic w_empty;
    logic w_wr_possible;
    logic w_rd_possible;
    logic w_wr_chosen;
    logic w_rd_chosen;
    logic w_wr_accept;
    logic w_rd_accept;

    assign w_idle        = (r_state == S_IDLE);
    assign w_full        = r_count[5];
    assign w_empty       = (r_count == 6'd0);
    assign w_wr_possible = wr_valid & ~w_full;
    assign w_rd_possible = rd_req & ~w_empty;

    // Priority only matters when both sides could go; otherwise the lone
    // requester wins regardless of RD_PRIORITY.
    assign w_rd_chosen = w_rd_possible & (RD_PRIORITY | ~w_wr_possible);
    assign w_wr_chosen = w_wr_possible & (~RD_PRIORITY | ~w_rd_possible);

    assign wr_ready    = w_idle & ~w_full & ~w_rd_chosen;
    assign rd_ready    = w_idle & ~w_empty & ~w_wr_chosen;
    assign w_wr_accept = wr_valid & wr_ready;
    assign w_rd_accept = rd_req & rd_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_wr_accept) begin
                    w_state_nxt = S_W_SETUP;
                end else if (w_rd_accept) begin
                    w_state_nxt = S_R_ADDR;
                end
            end
            S_W_SETUP:  w_state_nxt = S_W_PULSE;
            S_W_PULSE:  w_state_nxt = S_W_HOLD;
            S_W_HOLD:   w_state_nxt = S_IDLE;
            S_R_ADDR:   w_state_nxt = S_R_SAMPLE;
            S_R_SAMPLE: w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wptr     <= 5'd0;
            r_rptr     <= 5'd0;
            r_count    <= 6'd0;
            r_ram_we   <= 1'b0;
            r_ram_d    <= 8'd0;
            r_ram_a    <= 5'd0;
            r_rd_data  <= 8'd0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // Enable decoded from the next state so it leaves a flop cleanly.
            r_ram_we   <= (w_state_nxt == S_W_PULSE);
            r_rd_valid <= (r_state == S_R_SAMPLE);

            if (w_wr_accept) begin
                r_ram_a <= r_wptr;
                r_ram_d <= wr_data;
            end else if (w_rd_accept) begin
                r_ram_a <= r_rptr;
            end

            if (r_state == S_W_HOLD) begin
                r_wptr  <= r_wptr + 5'd1;
                r_count <= r_count + 6'd1;
            end

            if (r_state == S_R_SAMPLE) begin
                r_rd_data <= ram_o;
                r_rptr    <= r_rptr + 5'd1;
                r_count   <= r_count - 6'd1;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign ram_we   = r_ram_we;
    assign ram_d    = r_ram_d;
    assign ram_a    = r_ram_a;

endmodule
`default_nettype wire
